prom_xfer_arbiter: RTL

//  Shares the parameter-PROM -> slow-FIFO transfer engine between two requesters:
//  the power-up auto-load sequencer (REQ[0]) and the manual/JTAG reload path (REQ[1]).

---
 rtl/prom_arb_pkg.sv | 30 +++
 rtl/prom_arb_wdog.sv | 33 +++
 rtl/prom_xfer_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/prom_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prom_arb_pkg
//  Purpose  : Shared state encodings, requester indices and helpers for the
//             PROM transfer arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package prom_arb_pkg;

    // WAIT_BUSY and WAIT_DONE share code 3; the phase is tracked separately
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_DONE    = 3'd4,
        ST_TIMEOUT = 3'd5,
        ST_RELEASE = 3'd6,
        ST_TURN    = 3'd7
    } arb_state_t;

    localparam logic AL_IDX  = 1'b0;
    localparam logic MAN_IDX = 1'b1;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prom_arb_wdog.sv
`default_nettype none
// ============================================================================
//  Module   : prom_arb_wdog
//  Purpose  : 16-bit watchdog counter; clears, counts while enabled, saturates
//             at LIMIT and flags expiry while it holds there.
//  Revision : 1.0  initial release
// ============================================================================
module prom_arb_wdog #(
    parameter logic [15:0] LIMIT = 16'd40000
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [15:0] r_count;

    assign o_expired = (r_count == LIMIT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= 16'd0;
        end else if (i_clr) begin
            r_count <= 16'd0;
        end else if (i_en && !o_expired) begin
            r_count <= r_count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prom_xfer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : prom_xfer_arbiter
//  Purpose  : Shares the PROM->FIFO transfer engine between auto-load and
//             manual/JTAG requesters with watchdog and turnaround.
//             Define PROM_ARB_RR_EN for round-robin arbitration on ties.
//  Revision : 1.0  initial release
// ============================================================================
module prom_xfer_arbiter #(
    parameter logic [15:0] TMO_CYC  = 16'd40000,
    parameter logic [3:0]  TURN_CYC = 4'd3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] REQ,
    input  logic       XFER_DONE,
    output logic [1:0] GNT,
    output logic       XFER_START,
    output logic       XFER_ABORT,
    output logic [1:0] OWNER_DONE,
    output logic       TMO_ERR,
    output logic       ARB_BUSY,
    output logic [2:0] ARB_STATE
);

    import prom_arb_pkg::*;

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_owner;
    logic       r_busy_seen;
    logic [3:0] r_turn_cnt;
    logic       w_win;
    logic       w_owner_nxt;
    logic       w_expired;
    logic       w_turn_last;
    logic       w_wd_clr;
    logic       w_wd_en;
`ifdef PROM_ARB_RR_EN
    logic       r_last_owner;
`endif

    assign ARB_STATE   = r_state;
    assign w_turn_last = (TURN_CYC == 4'd0) || (r_turn_cnt == TURN_CYC - 4'd1);
    assign w_owner_nxt = (r_state == ST_IDLE) ? w_win : r_owner;
    assign w_wd_clr    = (w_next == ST_START);
    assign w_wd_en     = (r_state == ST_WAIT);

    always_comb begin
        w_win = REQ[AL_IDX] ? AL_IDX : MAN_IDX;
`ifdef PROM_ARB_RR_EN
        if (REQ[AL_IDX] && REQ[MAN_IDX]) begin
            w_win = ~r_last_owner;
        end
`endif
    end

    // Busy/done events take precedence over the watchdog on the same cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (|REQ) w_next = ST_GRANT;
            ST_GRANT:   w_next = ST_START;
            ST_START:   w_next = ST_WAIT;
            ST_WAIT: begin
                if (!r_busy_seen) begin
                    if (XFER_DONE && w_expired) w_next = ST_TIMEOUT;
                end else if (XFER_DONE) begin
                    w_next = ST_DONE;
                end else if (w_expired) begin
                    w_next = ST_TIMEOUT;
                end
            end
            ST_DONE:    w_next = ST_RELEASE;
            ST_TIMEOUT: w_next = ST_RELEASE;
            ST_RELEASE: if (!REQ[r_owner]) w_next = ST_TURN;
            ST_TURN:    if (w_turn_last) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    prom_arb_wdog #(
        .LIMIT     (TMO_CYC)
    ) u_wdog (
        .CLK       (CLK),
        .RST       (RST),
        .i_clr     (w_wd_clr),
        .i_en      (w_wd_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_busy_seen <= 1'b0;
            r_turn_cnt  <= 4'd0;
            GNT         <= 2'b00;
            XFER_START  <= 1'b0;
            XFER_ABORT  <= 1'b0;
            OWNER_DONE  <= 2'b00;
            TMO_ERR     <= 1'b0;
            ARB_BUSY    <= 1'b0;
`ifdef PROM_ARB_RR_EN
            r_last_owner <= 1'b1;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_next == ST_GRANT) begin
                r_owner <= w_win;
`ifdef PROM_ARB_RR_EN
                r_last_owner <= w_win;
`endif
            end
            if (w_next == ST_START) begin
                r_busy_seen <= 1'b0;
            end else if (r_state == ST_WAIT && !XFER_DONE) begin
                r_busy_seen <= 1'b1;
            end
            r_turn_cnt <= (r_state == ST_TURN) ? r_turn_cnt + 4'd1 : 4'd0;

            GNT        <= (w_next != ST_IDLE && w_next != ST_TURN) ? owner_onehot(w_owner_nxt) : 2'b00;
            XFER_START <= (w_next == ST_START);
            XFER_ABORT <= (w_next == ST_TIMEOUT);
            TMO_ERR    <= (w_next == ST_TIMEOUT);
            OWNER_DONE <= (w_next == ST_DONE) ? owner_onehot(r_owner) : 2'b00;
            ARB_BUSY   <= (w_next != ST_IDLE);
        end
    end

endmodule
`default_nettype wire
